// File: rtl/ttl_pkg.sv
// Shared types and next-count helper for the ttl_* counter/strobe blocks.
package ttl_pkg;

    localparam int CNT_MAX_W = 16;

    typedef enum logic {
        EDGE_FALL = 1'b0,
        EDGE_RISE = 1'b1
    } strobe_edge_t;

    typedef struct packed {
        logic [CNT_MAX_W-1:0] val;
        logic                 wrap;
    } cnt_res_t;

    // Out-of-range values (q >= modulus) run through to 2^width-1 and roll to 0 without a wrap flag.
    function automatic cnt_res_t cnt_next(input logic [CNT_MAX_W-1:0] q,
                                          input logic                 dn,
                                          input logic [CNT_MAX_W:0]   modulus,
                                          input int                   width);
        cnt_res_t             res;
        logic [CNT_MAX_W:0]   last;
        logic [CNT_MAX_W:0]   mask;
        logic [CNT_MAX_W:0]   nxt;
        last     = modulus - 17'd1;
        mask     = (17'd1 << width) - 17'd1;
        nxt      = '0;
        res.val  = '0;
        res.wrap = 1'b0;
        if (dn) begin
            if (q == '0) begin
                res.val  = 16'(last);
                res.wrap = 1'b1;
            end else begin
                res.val = q - 16'd1;
            end
        end else begin
            if ({1'b0, q} == last) begin
                res.wrap = 1'b1;
            end else begin
                nxt     = ({1'b0, q} + 17'd1) & mask;
                res.val = 16'(nxt);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/ttl_counter_if.sv
// Strobe/control/count bundle for ttl_counter; dn exists only with TTL_COUNTER_DOWN_EN.
interface ttl_counter_if #(parameter int WIDTH = 4);
    logic             cp;
    logic             mr;
    logic             _ld;
    logic [WIDTH-1:0] d;
    logic             enp;
    logic             ent;
`ifdef TTL_COUNTER_DOWN_EN
    logic             dn;
`endif
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             tick;

    modport master (
`ifdef TTL_COUNTER_DOWN_EN
        output dn,
`endif
        output cp, mr, _ld, d, enp, ent,
        input  q, tc, tick
    );

    modport slave (
`ifdef TTL_COUNTER_DOWN_EN
        input  dn,
`endif
        input  cp, mr, _ld, d, enp, ent,
        output q, tc, tick
    );
endinterface

// File: rtl/ttl_edge_det.sv
// Registered strobe edge detector; history resets to the idle level so the first active sample after reset fires.
module ttl_edge_det
    import ttl_pkg::*;
#(
    parameter strobe_edge_t EDGE = EDGE_FALL
) (
    input  logic clk,
    input  logic _rst,
    input  logic in,
    output logic fall
);
    logic r_hist;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_hist <= (EDGE == EDGE_FALL);
        end else begin
            r_hist <= in;
        end
    end

    assign fall = (EDGE == EDGE_FALL) ? (r_hist & ~in) : (~r_hist & in);
endmodule

// File: rtl/ttl_counter.sv
// Parametrised TTL-style synchronous counter driven by a sampled cp strobe.
// Down-counting and the dn port are enabled with TTL_COUNTER_DOWN_EN.
module ttl_counter
    import ttl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic          clk,
    input  logic          _rst,
    ttl_counter_if.slave  bus
);
    localparam logic [CNT_MAX_W:0] MOD_L = 17'(MODULUS);
    localparam logic [WIDTH-1:0]   LAST  = WIDTH'(MODULUS - 1);

    logic             r_tick;
    logic [WIDTH-1:0] r_q;
    logic             w_stb;
    logic             w_dn;
    cnt_res_t         w_nxt;
    logic [WIDTH-1:0] w_nxt_q;

`ifdef TTL_COUNTER_DOWN_EN
    assign w_dn = bus.dn;
`else
    assign w_dn = 1'b0;
`endif

    ttl_edge_det #(.EDGE(EDGE_FALL)) u_cp_edge (
        .clk  (clk),
        ._rst (_rst),
        .in   (bus.cp),
        .fall (w_stb)
    );

    assign w_nxt   = cnt_next(16'(r_q), w_dn, MOD_L, WIDTH);
    assign w_nxt_q = WIDTH'(w_nxt.val);

    // mr beats load beats count; a strobe coincident with mr is dropped.
    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_q    <= '0;
            r_tick <= 1'b0;
        end else if (bus.mr) begin
            r_q    <= '0;
            r_tick <= 1'b0;
        end else if (w_stb && !bus._ld) begin
            r_q    <= bus.d;
            r_tick <= 1'b0;
        end else if (w_stb && bus.enp && bus.ent) begin
            r_q    <= w_nxt_q;
            r_tick <= w_nxt.wrap;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign bus.q    = r_q;
    assign bus.tick = r_tick;

    // tc ignores enp and cp so a downstream stage can cascade on ent <= tc.
`ifdef TTL_COUNTER_DOWN_EN
    assign bus.tc = bus.ent & (w_dn ? (r_q == '0) : (r_q == LAST));
`else
    assign bus.tc = bus.ent & (r_q == LAST);
`endif
endmodule

// File: tb/tb_ttl_counter.sv
// Directed bench for ttl_counter: modulus-16 and decade instances (plus a modulus-6 down instance with TTL_COUNTER_DOWN_EN).
module tb_ttl_counter;
    logic       clk = 1'b0;
    logic       rst_b;
    logic       cp, mr, ld_b, enp, ent, dn;
    logic [3:0] d;

    int n_chk  = 0;
    int n_fail = 0;

    logic [3:0] cap_q16, cap_q10;
    logic       cap_t16, cap_t10;

    always #5 clk = ~clk;

    ttl_counter_if #(.WIDTH(4)) if16 ();
    ttl_counter_if #(.WIDTH(4)) if10 ();

    assign if16.cp = cp;  assign if16.mr = mr;  assign if16._ld = ld_b;
    assign if16.d = d;    assign if16.enp = enp; assign if16.ent = ent;
    assign if10.cp = cp;  assign if10.mr = mr;  assign if10._ld = ld_b;
    assign if10.d = d;    assign if10.enp = enp; assign if10.ent = ent;

    ttl_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (.clk(clk), ._rst(rst_b), .bus(if16));
    ttl_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (.clk(clk), ._rst(rst_b), .bus(if10));

`ifdef TTL_COUNTER_DOWN_EN
    logic [2:0] cap_q6;
    logic       cap_t6;
    ttl_counter_if #(.WIDTH(3)) if6 ();
    assign if16.dn = dn;  assign if10.dn = dn;  assign if6.dn = dn;
    assign if6.cp = cp;   assign if6.mr = mr;   assign if6._ld = ld_b;
    assign if6.d = d[2:0]; assign if6.enp = enp; assign if6.ent = ent;
    ttl_counter #(.WIDTH(3), .MODULUS(6)) u_dut6 (.clk(clk), ._rst(rst_b), .bus(if6));
`endif

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One count event: cp low for one sampled cycle (captures q/tick right after the count edge), then high.
    task automatic pulse();
        cp = 1'b0;
        @(posedge clk); #1;
        cap_q16 = if16.q;  cap_t16 = if16.tick;
        cap_q10 = if10.q;  cap_t10 = if10.tick;
`ifdef TTL_COUNTER_DOWN_EN
        cap_q6 = if6.q;    cap_t6 = if6.tick;
`endif
        cp = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic clear();
        mr = 1'b1;
        @(posedge clk); #1;
        mr = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_b = 1'b0; cp = 1'b1; mr = 1'b0; ld_b = 1'b1; d = 4'd0;
        enp = 1'b1; ent = 1'b1; dn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_q16",   32'(if16.q),    0);
        check_val("rst_tick16", 32'(if16.tick), 0);
        check_val("rst_q10",   32'(if10.q),    0);
        check_val("rst_tc16",  32'(if16.tc),   0);
        #2 rst_b = 1'b1;
        @(posedge clk); #1;

        for (int i = 1; i <= 17; i++) begin
            pulse();
            check_val($sformatf("up16_q[%0d]", i),    32'(cap_q16), i % 16);
            check_val($sformatf("up16_tick[%0d]", i), 32'(cap_t16), (i == 16) ? 1 : 0);
            check_val($sformatf("up16_tc[%0d]", i),   32'(if16.tc), ((i % 16) == 15) ? 1 : 0);
        end

        clear();
        check_val("mr_q10", 32'(if10.q), 0);
        for (int i = 1; i <= 10; i++) begin
            pulse();
            check_val($sformatf("dec_q[%0d]", i),    32'(cap_q10), i % 10);
            check_val($sformatf("dec_tick[%0d]", i), 32'(cap_t10), (i == 10) ? 1 : 0);
            check_val($sformatf("dec_tc[%0d]", i),   32'(if10.tc), ((i % 10) == 9) ? 1 : 0);
        end
        repeat (9) pulse();
        check_val("dec_q9",    32'(if10.q),  9);
        check_val("dec_tc_q9", 32'(if10.tc), 1);
        ent = 1'b0; #1;
        check_val("ent0_tc", 32'(if10.tc), 0);
        repeat (3) pulse();
        check_val("ent0_hold_q",    32'(if10.q),  9);
        check_val("ent0_hold_tick", 32'(cap_t10), 0);
        ent = 1'b1; #1;
        check_val("ent1_tc", 32'(if10.tc), 1);

        ld_b = 1'b0; d = 4'd12;
        pulse();
        ld_b = 1'b1;
        check_val("load_q10",   32'(cap_q10), 12);
        check_val("load_tick",  32'(cap_t10), 0);
        check_val("load_q16",   32'(cap_q16), 12);
        for (int i = 1; i <= 4; i++) begin
            pulse();
            check_val($sformatf("oor_q[%0d]", i),    32'(cap_q10), (12 + i) % 16);
            check_val($sformatf("oor_tick[%0d]", i), 32'(cap_t10), 0);
        end
        pulse();
        check_val("pre_mr_q", 32'(if10.q), 1);
        mr = 1'b1; cp = 1'b0;
        @(posedge clk); #1;
        check_val("mr_stb_q",    32'(if10.q),    0);
        check_val("mr_stb_tick", 32'(if10.tick), 0);
        mr = 1'b0; cp = 1'b1;
        @(posedge clk); #1;
        check_val("mr_stb_after", 32'(if10.q), 0);

        cp = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check_val("cp_low_q", 32'(if10.q), 1);
        cp = 1'b1;
        @(posedge clk); #1;
        check_val("cp_high_q", 32'(if10.q), 1);
        for (int i = 0; i < 4; i++) begin
            pulse();
            check_val($sformatf("toggle_q[%0d]", i), 32'(cap_q10), 2 + i);
            check_val($sformatf("toggle_hold[%0d]", i), 32'(if10.q), 2 + i);
        end

`ifdef TTL_COUNTER_DOWN_EN
        clear();
        dn = 1'b1; #1;
        check_val("dn_tc_q0", 32'(if6.tc), 1);
        pulse();
        check_val("dn_wrap_q",    32'(cap_q6), 5);
        check_val("dn_wrap_tick", 32'(cap_t6), 1);
        check_val("dn_tc_q5",     32'(if6.tc), 0);
        pulse();
        check_val("dn_q4",      32'(cap_q6), 4);
        check_val("dn_q4_tick", 32'(cap_t6), 0);
        clear();
        check_val("dn_flip_tc1", 32'(if6.tc), 1);
        dn = 1'b0; #1;
        check_val("dn_flip_tc0", 32'(if6.tc), 0);
`endif

        clear();
        repeat (7) pulse();
        check_val("pre_rst_q", 32'(if10.q), 7);
        cp = 1'b0;
        #2 rst_b = 1'b0;
        #1;
        check_val("async_rst_q",    32'(if10.q),    0);
        check_val("async_rst_tick", 32'(if10.tick), 0);
        check_val("async_rst_q16",  32'(if16.q),    0);
        @(posedge clk); #1;
        check_val("in_rst_q", 32'(if10.q), 0);
        #2 rst_b = 1'b1;
        @(posedge clk); #1;
        check_val("post_rst_q10", 32'(if10.q), 1);
        check_val("post_rst_q16", 32'(if16.q), 1);
        cp = 1'b1;
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ttl_counter.md
# ttl_counter

Parametrised synchronous counter for the TTL-recreation netlists. It supersedes the hard-wired 4-bit ripple counter and adds:
- configurable width and modulus;
- parallel load, dual count enables and terminal-count output;
- optional down-counting.

All state advances on the single system clock. The legacy TTL clock pin becomes a sampled strobe, so one block serves the 7490/7493/74161/74191-style counters in the video and score chains without derived clocks.

## Interface
- WIDTH, 4, counter width in bits (1..16).
- MODULUS, 16, count length; legal range 2..2^WIDTH; wrap point is MODULUS-1.
- clk  in  1  system clock; all state changes on its rising edge.
- _rst  in  1  asynchronous, active-low reset.
- cp  in  1  TTL count strobe, synchronous to clk; a falling edge (sampled 1 then 0) is one count event.
- mr  in  1  synchronous master clear, active-high, not gated by cp.
- _ld  in  1  active-low parallel load, acts on a cp falling edge.
- d  in  WIDTH  parallel load data.
- enp, ent  in  1  count enables; both must be 1 to count.
- dn  in  1  direction (1 = down); present only with TTL_COUNTER_DOWN_EN.
- q  out  WIDTH  count value, registered.
- tc  out  1  terminal count, combinational from q and ent.
- tick  out  1  registered one-cycle wrap pulse.

## Operation
- Reset (_rst low): q=0, tick=0, strobe history cp_q=1. The first low cp sample after reset therefore counts.
- Strobe event: stb = cp_q & ~cp. cp_q <= cp every clk.
- Priority per clk edge is mr, then load, then count:
  - mr=1: q=0, tick=0.
  - Otherwise stb & ~_ld: q=d. Any d value is accepted, including d ≥ MODULUS. tick=0.
  - Otherwise stb & enp & ent: count.
  - Otherwise: hold; tick=0.
- Up count:
  - q==MODULUS-1 gives q=0 and tick=1.
  - Any other q gives q+1 modulo 2^WIDTH; out-of-range values run to 2^WIDTH-1, then 0, with no tick.
- Down count:
  - q==0 gives q=MODULUS-1 and tick=1.
  - Any other q gives q-1. Out-of-range values descend normally.
- tc:
  - Up: tc = ent & (q==MODULUS-1).
  - Down: tc = ent & (q==0).
  - tc ignores enp and cp, so counters can be cascaded via ent←tc.
- dn may change at any time. It takes effect on the next strobe, and tc follows it combinationally.

## Timing
- Latency: q changes on the clk edge that first samples cp=0 after cp=1. The new value is visible one cycle after cp is first presented low.
- cp held low produces exactly one event. A new event needs cp high for ≥1 sampled cycle.
- tick is high for exactly one clk cycle, coincident with the wrapped q value.
- mr is effective on the next clk edge regardless of cp. A strobe in the same cycle is discarded.
- _rst assertion mid-count clears immediately (asynchronous). Deassertion is synchronised outside the block.
- Maximum event rate: one per 2 clk cycles.

## Configuration
- TTL_COUNTER_DOWN_EN:
  - Defined: port dn exists and down-counting applies as above.
  - Undefined: no dn port; the counter is up-only; tc uses the up rule only.

## Structure
- Package ttl_pkg:
  - Function cnt_next(q, dn, modulus, width) returning the next value and a wrap flag.
  - Localparam/typedef for the strobe-edge type.
  - Shared with other ttl_* blocks.
- Sub-module ttl_edge_det: registered falling-edge detector (clk, _rst, in, fall). Reset history is 1. Reused by the other strobe-driven TTL models.

## Test plan
- Reset, WIDTH=4, MODULUS=16, enp=ent=1, 17 cp pulses → q counts 0..15, then 0; one tick on the 16th pulse; tc=1 only while q=15.
- MODULUS=10 decade: from 0, 10 pulses → q=9 then 0 with tick; tc high at q=9; with ent=0, tc=0 and q holds across pulses.
- Load: _ld=0, d=12, MODULUS=10, one pulse → q=12. Four more pulses → 13, 14, 15, 0 with no tick. Then mr=1 with a simultaneous strobe → q=0.
- cp held low 5 cycles → exactly one increment. cp toggling every cycle → one increment per 2 cycles.
- With TTL_COUNTER_DOWN_EN, MODULUS=6, dn=1 from q=0, one pulse → q=5 with tick. Flipping dn at q=0 moves tc 1→0 in the same cycle.
- _rst pulled low mid-sequence at q=7 → q=0 and tick=0 immediately. The first low cp after release counts to 1.
